// File: rtl/cpu_datapath_pkg.sv
// Shared definitions for the single-bus CPU datapath.
//   WORD       : native datapath word width
//   bus_src_e  : bus sources, listed from highest to lowest priority
//   alu_op_e   : ALU operations (INC beats SUB beats ADD when strobes collide)
package cpu_datapath_pkg;

    localparam int unsigned WORD = 32;

    typedef enum logic [3:0] {
        SrcPc,
        SrcZhigh,
        SrcZlow,
        SrcMdr,
        SrcR2,
        SrcR3,
        SrcR7,
        SrcHi,
        SrcLo,
        SrcInPort,
        SrcC,
        SrcNone
    } bus_src_e;

    typedef enum logic [1:0] {
        AluAdd,
        AluSub,
        AluInc
    } alu_op_e;

endpackage

// File: rtl/reg32.sv
// Generic datapath register with synchronous clear and load enable.
//   clk : rising-edge clock
//   clr : synchronous active-high clear, loads RESET_VAL, beats en
//   en  : load enable
//   d   : data in
//   q   : register contents
module reg32 #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu_datapath.sv
// 32-bit single-bus CPU datapath, sequenced one strobe set per clock.
//   clk, clr            : clock and synchronous active-high reset
//   MDatain, InPort     : memory read data, external input port
//   *out                : bus source selects (fixed priority if several are set)
//   *in                 : register load enables, value taken from the bus
//   Read                : MDR loads MDatain instead of the bus
//   IncPC, SUB          : ALU op select (default is Y + bus)
//   BusMuxOut           : current bus value
//   MAR_q, IR_q, R*_q   : register contents for observation
//   Z_q                 : 64-bit ALU result register {Zhigh, Zlow}
module cpu_datapath
    import cpu_datapath_pkg::*;
#(
    parameter int unsigned      WIDTH    = WORD,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [WIDTH-1:0]   MDatain,
    input  logic [WIDTH-1:0]   InPort,
    input  logic               PCout,
    input  logic               Zlowout,
    input  logic               Zhighout,
    input  logic               MDRout,
    input  logic               R2out,
    input  logic               R3out,
    input  logic               R7out,
    input  logic               LOout,
    input  logic               HIout,
    input  logic               InPortout,
    input  logic               Cout,
    input  logic               R1in,
    input  logic               R2in,
    input  logic               R3in,
    input  logic               PCin,
    input  logic               IRin,
    input  logic               MARin,
    input  logic               MDRin,
    input  logic               Yin,
    input  logic               Zin,
    input  logic               Read,
    input  logic               IncPC,
    input  logic               SUB,
    output logic [WIDTH-1:0]   BusMuxOut,
    output logic [WIDTH-1:0]   MAR_q,
    output logic [WIDTH-1:0]   IR_q,
    output logic [WIDTH-1:0]   R1_q,
    output logic [WIDTH-1:0]   R2_q,
    output logic [WIDTH-1:0]   R3_q,
    output logic [2*WIDTH-1:0] Z_q
);

    logic [WIDTH-1:0]   pc_q, mdr_q, y_q, hi_q, lo_q, r7_q;
    logic [WIDTH-1:0]   mdr_d;
    logic [WIDTH-1:0]   c_sext;
    logic [WIDTH-1:0]   alu_lo, alu_hi;
    bus_src_e           bus_src;
    alu_op_e            alu_op;

    // Immediate field IR[18:0], sign-extended onto the bus.
    assign c_sext = {{(WIDTH-19){IR_q[18]}}, IR_q[18:0]};

    always_comb begin
        bus_src = SrcNone;
        if      (PCout)     bus_src = SrcPc;
        else if (Zhighout)  bus_src = SrcZhigh;
        else if (Zlowout)   bus_src = SrcZlow;
        else if (MDRout)    bus_src = SrcMdr;
        else if (R2out)     bus_src = SrcR2;
        else if (R3out)     bus_src = SrcR3;
        else if (R7out)     bus_src = SrcR7;
        else if (HIout)     bus_src = SrcHi;
        else if (LOout)     bus_src = SrcLo;
        else if (InPortout) bus_src = SrcInPort;
        else if (Cout)      bus_src = SrcC;
    end

    always_comb begin
        BusMuxOut = '0;
        case (bus_src)
            SrcPc:     BusMuxOut = pc_q;
            SrcZhigh:  BusMuxOut = Z_q[2*WIDTH-1:WIDTH];
            SrcZlow:   BusMuxOut = Z_q[WIDTH-1:0];
            SrcMdr:    BusMuxOut = mdr_q;
            SrcR2:     BusMuxOut = R2_q;
            SrcR3:     BusMuxOut = R3_q;
            SrcR7:     BusMuxOut = r7_q;
            SrcHi:     BusMuxOut = hi_q;
            SrcLo:     BusMuxOut = lo_q;
            SrcInPort: BusMuxOut = InPort;
            SrcC:      BusMuxOut = c_sext;
            default:   BusMuxOut = '0;
        endcase
    end

    assign mdr_d = Read ? MDatain : BusMuxOut;

    always_comb begin
        alu_op = AluAdd;
        if (IncPC) begin
            alu_op = AluInc;
        end else if (SUB) begin
            alu_op = AluSub;
        end
    end

    // Zhigh is zero for increment, otherwise the sign of the 32-bit result.
    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        case (alu_op)
            AluInc: begin
                alu_lo = BusMuxOut + WIDTH'(1);
                alu_hi = '0;
            end
            AluSub: begin
                alu_lo = y_q - BusMuxOut;
                alu_hi = {WIDTH{alu_lo[WIDTH-1]}};
            end
            default: begin
                alu_lo = y_q + BusMuxOut;
                alu_hi = {WIDTH{alu_lo[WIDTH-1]}};
            end
        endcase
    end

    reg32 #(.WIDTH(WIDTH), .RESET_VAL(PC_RESET)) u_pc (
        .clk(clk), .clr(clr), .en(PCin), .d(BusMuxOut), .q(pc_q));
    reg32 #(.WIDTH(WIDTH)) u_ir (
        .clk(clk), .clr(clr), .en(IRin), .d(BusMuxOut), .q(IR_q));
    reg32 #(.WIDTH(WIDTH)) u_mar (
        .clk(clk), .clr(clr), .en(MARin), .d(BusMuxOut), .q(MAR_q));
    reg32 #(.WIDTH(WIDTH)) u_mdr (
        .clk(clk), .clr(clr), .en(MDRin), .d(mdr_d), .q(mdr_q));
    reg32 #(.WIDTH(WIDTH)) u_y (
        .clk(clk), .clr(clr), .en(Yin), .d(BusMuxOut), .q(y_q));
    reg32 #(.WIDTH(WIDTH)) u_r1 (
        .clk(clk), .clr(clr), .en(R1in), .d(BusMuxOut), .q(R1_q));
    reg32 #(.WIDTH(WIDTH)) u_r2 (
        .clk(clk), .clr(clr), .en(R2in), .d(BusMuxOut), .q(R2_q));
    reg32 #(.WIDTH(WIDTH)) u_r3 (
        .clk(clk), .clr(clr), .en(R3in), .d(BusMuxOut), .q(R3_q));
    reg32 #(.WIDTH(2*WIDTH)) u_z (
        .clk(clk), .clr(clr), .en(Zin), .d({alu_hi, alu_lo}), .q(Z_q));

    // HI, LO and R7 have no load path here; they only ever hold the reset value.
    reg32 #(.WIDTH(WIDTH)) u_hi (
        .clk(clk), .clr(clr), .en(1'b0), .d(BusMuxOut), .q(hi_q));
    reg32 #(.WIDTH(WIDTH)) u_lo (
        .clk(clk), .clr(clr), .en(1'b0), .d(BusMuxOut), .q(lo_q));
    reg32 #(.WIDTH(WIDTH)) u_r7 (
        .clk(clk), .clr(clr), .en(1'b0), .d(BusMuxOut), .q(r7_q));

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed test-plan sequence plus random strobe
// sequences. The driver pushes expectations tagged with the negedge on which
// they hold; an independent monitor checks every entry due at each negedge.
module tb_cpu_datapath;

    localparam int OBS_BUS = 0;
    localparam int OBS_MAR = 1;
    localparam int OBS_IR  = 2;
    localparam int OBS_R1  = 3;
    localparam int OBS_R2  = 4;
    localparam int OBS_R3  = 5;
    localparam int OBS_Z   = 6;

    typedef struct {
        int          cyc;
        int          obs;
        logic [63:0] val;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] mdat, inport;
    // sel bit order = bus priority: PC, Zhigh, Zlow, MDR, R2, R3, R7, HI, LO, InPort, C
    logic [10:0] sel;
    // ld bit order: R1, R2, R3, PC, IR, MAR, MDR, Y, Z
    logic [8:0]  ld;
    logic        rd, inc, sub;
    logic [31:0] bus, mar, ir, r1, r2, r3;
    logic [63:0] z;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // Reference state
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_r1, m_r2, m_r3;
    logic [63:0] m_z;

    always #5 clk = ~clk;

    cpu_datapath #(.WIDTH(32), .PC_RESET(32'h0)) dut (
        .clk(clk), .clr(clr), .MDatain(mdat), .InPort(inport),
        .PCout(sel[0]), .Zhighout(sel[1]), .Zlowout(sel[2]), .MDRout(sel[3]),
        .R2out(sel[4]), .R3out(sel[5]), .R7out(sel[6]), .HIout(sel[7]),
        .LOout(sel[8]), .InPortout(sel[9]), .Cout(sel[10]),
        .R1in(ld[0]), .R2in(ld[1]), .R3in(ld[2]), .PCin(ld[3]), .IRin(ld[4]),
        .MARin(ld[5]), .MDRin(ld[6]), .Yin(ld[7]), .Zin(ld[8]),
        .Read(rd), .IncPC(inc), .SUB(sub),
        .BusMuxOut(bus), .MAR_q(mar), .IR_q(ir), .R1_q(r1), .R2_q(r2), .R3_q(r3),
        .Z_q(z));

    function automatic logic [63:0] actual(int o);
        case (o)
            OBS_BUS: return {32'h0, bus};
            OBS_MAR: return {32'h0, mar};
            OBS_IR:  return {32'h0, ir};
            OBS_R1:  return {32'h0, r1};
            OBS_R2:  return {32'h0, r2};
            OBS_R3:  return {32'h0, r3};
            default: return z;
        endcase
    endfunction

    // Monitor: check everything due at this negedge; anything overdue is a miss.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                checks = checks + 1;
                if (exp_q[i].cyc < cyc) begin
                    failures = failures + 1;
                    $display("FAIL %s: expectation overdue (due %0d, now %0d)",
                             exp_q[i].nm, exp_q[i].cyc, cyc);
                end else if (actual(exp_q[i].obs) !== exp_q[i].val) begin
                    failures = failures + 1;
                    $display("FAIL %s @%0d: got %h expected %h", exp_q[i].nm, cyc,
                             actual(exp_q[i].obs), exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    task automatic expect_at(int dly, int o, logic [63:0] v, string nm);
        exp_t e;
        e.cyc = cyc + dly;
        e.obs = o;
        e.val = v;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] src_val(int i);
        case (i)
            0:       return m_pc;
            1:       return m_z[63:32];
            2:       return m_z[31:0];
            3:       return m_mdr;
            4:       return m_r2;
            5:       return m_r3;
            9:       return inport;
            10:      return {{13{m_ir[18]}}, m_ir[18:0]};
            default: return 32'h0; // R7, HI, LO never load
        endcase
    endfunction

    function automatic logic [31:0] model_bus();
        for (int i = 0; i < 11; i++) begin
            if (sel[i]) return src_val(i);
        end
        return 32'h0;
    endfunction

    // Drive one cycle of strobes and queue the model's expectations:
    // the bus mid-cycle (next negedge), registers after the edge (one later).
    task automatic drive(logic [10:0] s, logic [8:0] l, logic r, logic ic, logic sb,
                         logic [31:0] md, logic [31:0] ip, logic c);
        logic [31:0] b, d;
        logic [63:0] res;
        sel = s; ld = l; rd = r; inc = ic; sub = sb; mdat = md; inport = ip; clr = c;
        b = model_bus();
        expect_at(1, OBS_BUS, {32'h0, b}, "bus");
        if (ic) begin
            d   = b + 32'd1;
            res = {32'h0, d};
        end else if (sb) begin
            d   = m_y - b;
            res = {{32{d[31]}}, d};
        end else begin
            d   = m_y + b;
            res = {{32{d[31]}}, d};
        end
        if (c) begin
            m_pc = 32'h0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0;
            m_r1 = 0; m_r2 = 0; m_r3 = 0; m_z = 64'h0;
        end else begin
            if (l[0]) m_r1  = b;
            if (l[1]) m_r2  = b;
            if (l[2]) m_r3  = b;
            if (l[3]) m_pc  = b;
            if (l[4]) m_ir  = b;
            if (l[5]) m_mar = b;
            if (l[6]) m_mdr = r ? md : b;
            if (l[7]) m_y   = b;
            if (l[8]) m_z   = res;
        end
        expect_at(2, OBS_MAR, {32'h0, m_mar}, "mar");
        expect_at(2, OBS_IR,  {32'h0, m_ir},  "ir");
        expect_at(2, OBS_R1,  {32'h0, m_r1},  "r1");
        expect_at(2, OBS_R2,  {32'h0, m_r2},  "r2");
        expect_at(2, OBS_R3,  {32'h0, m_r3},  "r3");
        expect_at(2, OBS_Z,   m_z,            "z");
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shorthands: selects and loads as one-hot bits
    localparam logic [10:0] S_PC = 11'd1 << 0, S_ZH = 11'd1 << 1, S_ZL = 11'd1 << 2,
                            S_MDR = 11'd1 << 3, S_R2 = 11'd1 << 4, S_R3 = 11'd1 << 5,
                            S_IN = 11'd1 << 9, S_C = 11'd1 << 10, S_NONE = 11'd0;
    localparam logic [8:0]  L_R1 = 9'd1 << 0, L_R2 = 9'd1 << 1, L_R3 = 9'd1 << 2,
                            L_PC = 9'd1 << 3, L_IR = 9'd1 << 4, L_MAR = 9'd1 << 5,
                            L_MDR = 9'd1 << 6, L_Y = 9'd1 << 7, L_Z = 9'd1 << 8,
                            L_NONE = 9'd0;

    initial begin
        m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0;
        m_r1 = 0; m_r2 = 0; m_r3 = 0; m_z = 0;
        sel = 0; ld = 0; rd = 0; inc = 0; sub = 0; mdat = 0; inport = 0; clr = 1;
        tick();

        // Reset
        drive(S_NONE, L_NONE, 0, 0, 0, 32'h0, 32'h0, 1);
        tick();
        expect_at(1, OBS_R1, 64'h0, "reset_r1");
        expect_at(1, OBS_R2, 64'h0, "reset_r2");
        expect_at(1, OBS_MAR, 64'h0, "reset_mar");
        expect_at(1, OBS_Z, 64'h0, "reset_z");

        // Register loads through MDR
        drive(S_NONE, L_MDR, 1, 0, 0, 32'd10, 32'h0, 0); tick();
        drive(S_MDR, L_R2, 0, 0, 0, 32'h0, 32'h0, 0); tick();
        expect_at(1, OBS_R2, 64'd10, "load_r2_10");
        drive(S_NONE, L_MDR, 1, 0, 0, 32'd15, 32'h0, 0); tick();
        drive(S_MDR, L_R3, 0, 0, 0, 32'h0, 32'h0, 0); tick();
        expect_at(1, OBS_R3, 64'd15, "load_r3_15");
        drive(S_NONE, L_MDR, 1, 0, 0, 32'd0, 32'h0, 0); tick();
        drive(S_MDR, L_R1, 0, 0, 0, 32'h0, 32'h0, 0); tick();
        expect_at(1, OBS_R1, 64'd0, "load_r1_0");

        // Fetch
        drive(S_PC, L_MAR | L_Z, 0, 1, 0, 32'h0, 32'h0, 0); tick();
        expect_at(1, OBS_MAR, 64'h0, "fetch_t0_mar");
        expect_at(1, OBS_Z, 64'h1, "fetch_t0_z");
        drive(S_ZL, L_PC | L_MDR, 1, 0, 0, 32'h28918000, 32'h0, 0); tick();
        drive(S_MDR, L_IR, 0, 0, 0, 32'h0, 32'h0, 0);
        expect_at(1, OBS_BUS, 64'h28918000, "fetch_t2_mdr");
        tick();
        expect_at(1, OBS_IR, 64'h28918000, "fetch_t2_ir");

        // Bus priority: PCout beats R2out (PC=1, R2=10)
        drive(S_PC | S_R2, L_NONE, 0, 0, 0, 32'h0, 32'h0, 0);
        expect_at(1, OBS_BUS, 64'h1, "prio_pc_over_r2");
        tick();

        // SUB execute: R2 - R3
        drive(S_R2, L_Y, 0, 0, 0, 32'h0, 32'h0, 0); tick();
        drive(S_R3, L_Z, 0, 0, 1, 32'h0, 32'h0, 0); tick();
        expect_at(1, OBS_Z, 64'hFFFFFFFF_FFFFFFFB, "sub_z");
        drive(S_ZL, L_R1, 0, 0, 0, 32'h0, 32'h0, 0); tick();
        expect_at(1, OBS_R1, 64'hFFFFFFFB, "sub_r1");

        // Idle bus
        drive(S_NONE, L_NONE, 0, 0, 0, 32'h0, 32'h0, 0);
        expect_at(1, OBS_BUS, 64'h0, "bus_idle");
        tick();

        // Cout sign extension of IR[18:0]
        drive(S_NONE, L_MDR, 1, 0, 0, 32'h0007FFFF, 32'h0, 0); tick();
        drive(S_MDR, L_IR, 0, 0, 0, 32'h0, 32'h0, 0); tick();
        drive(S_C, L_NONE, 0, 0, 0, 32'h0, 32'h0, 0);
        expect_at(1, OBS_BUS, 64'hFFFFFFFF, "cout_neg");
        tick();
        drive(S_NONE, L_MDR, 1, 0, 0, 32'h0003FFFF, 32'h0, 0); tick();
        drive(S_MDR, L_IR, 0, 0, 0, 32'h0, 32'h0, 0); tick();
        drive(S_C, L_NONE, 0, 0, 0, 32'h0, 32'h0, 0);
        expect_at(1, OBS_BUS, 64'h0003FFFF, "cout_pos");
        tick();

        // Reset mid-sequence overrides R2in (PC was 1)
        drive(S_IN, L_R2, 0, 0, 0, 32'h0, 32'd7, 1); tick();
        expect_at(1, OBS_R2, 64'h0, "midreset_r2");
        drive(S_PC, L_NONE, 0, 0, 0, 32'h0, 32'h0, 0);
        expect_at(1, OBS_BUS, 64'h0, "midreset_pc");
        tick();

        // PC increment wrap
        drive(S_IN, L_PC, 0, 0, 0, 32'h0, 32'hFFFFFFFF, 0); tick();
        drive(S_PC, L_Z, 0, 1, 0, 32'h0, 32'h0, 0);
        expect_at(1, OBS_BUS, 64'hFFFFFFFF, "wrap_pc_max");
        tick();
        expect_at(1, OBS_Z, 64'h0, "wrap_z");
        drive(S_ZL, L_PC, 0, 0, 0, 32'h0, 32'h0, 0); tick();
        drive(S_PC, L_NONE, 0, 0, 0, 32'h0, 32'h0, 0);
        expect_at(1, OBS_BUS, 64'h0, "wrap_pc_zero");
        tick();

        // Random strobe sequences
        for (int n = 0; n < 600; n++) begin
            logic [10:0] s;
            if ($urandom_range(0, 3) == 0) s = 11'($urandom);
            else                           s = 11'd1 << $urandom_range(0, 10);
            drive(s, 9'($urandom) & 9'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom, $urandom, $urandom_range(0, 39) == 0);
            tick();
        end

        drive(S_NONE, L_NONE, 0, 0, 0, 32'h0, 32'h0, 0);
        repeat (3) tick();
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- 32-bit single-bus CPU datapath driven cycle-by-cycle by external control strobes (control unit or testbench FSM).
- Contains:
  - general registers R1, R2, R3, R7
  - PC, IR, MAR, MDR
  - ALU input latch Y, 64-bit result register Z (Zhigh:Zlow), HI, LO
  - a shared bus multiplexer and an ALU with add, subtract and increment.
- Sits between the control sequencer and memory: MDatain is the memory read-data input; MAR, the bus and the register values are exported for observation.

Parameters:
- WIDTH, 32, datapath/bus word width. Z is 2*WIDTH.
- PC_RESET, 0, PC value after reset.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- MDatain  in  32  memory read data
- InPort  in  32  external input-port value
- Bus-source selects (each in, 1): PCout, Zlowout, Zhighout, MDRout, R2out, R3out, R7out, LOout, HIout, InPortout, Cout
- Load enables (each in, 1): R1in, R2in, R3in, PCin, IRin, MARin, MDRin, Yin, Zin
- Read  in  1  MDR takes MDatain instead of the bus
- IncPC  in  1  ALU op: bus + 1
- SUB  in  1  ALU op: Y - bus
- BusMuxOut  out  32  current bus value
- MAR_q  out  32  memory address
- IR_q  out  32  instruction register
- R1_q, R2_q, R3_q  out  32 each  register contents
- Z_q  out  64  Z register

Behaviour:
- Reset:
  - On a rising clk edge with clr=1, every register is loaded with 0; PC is loaded with PC_RESET.
  - clr has priority over all load enables.
  - If clr is asserted mid-sequence, the next edge clears regardless of the strobes.
- Bus (combinational):
  - Exactly one source select is expected.
  - If several are asserted, a fixed priority applies: PCout > Zhighout > Zlowout > MDRout > R2out > R3out > R7out > HIout > LOout > InPortout > Cout.
  - With no select asserted, the bus is 0.
- Cout drives IR[18:0] sign-extended to 32 bits.
- Registers:
  - All update only on rising clk, when their in-strobe is high: value <= bus.
  - MDR exception: it loads (Read ? MDatain : bus) when MDRin=1.
  - Read without MDRin has no effect.
- ALU (combinational):
  - A = Y, B = bus. Priority IncPC > SUB > default.
  - IncPC: result = B + 1, zero-extended into Zhigh.
  - SUB: result = A - B, 32-bit two's complement; Zhigh = sign extension of bit 31.
  - Default: result = A + B; Zhigh = sign extension.
  - Z <= {Zhigh, Zlow} on clk when Zin=1.
- HI, LO, R7: present with out-selects only; in this block they load only via reset (value 0).
- Latency: any bus transfer completes in one clock. A full register-register ALU op takes 3 cycles: Yin, then Zin, then Zlowout to the destination.
- Same-cycle read and write of a register: the bus carries the old value; the new value appears after the edge.
- Arithmetic wraps modulo 2^32 with no flags. PC increment wraps 0xFFFFFFFF to 0.

Decomposition:
- Shared package holds:
  - WORD = 32 constant
  - bus-source enumeration with its priority order
  - ALU op enumeration: ADD, SUB, INC
- One sub-module, reg32: WIDTH-bit register with synchronous clr and load enable, instantiated for every register.
- MDR input mux, bus mux and ALU stay in cpu_datapath.

Test Plan:
- Register loads: reset, then Read+MDRin with MDatain=10, then MDRout+R2in → R2_q=10. Repeat with 15 into R3 and 0 into R1 → R3_q=15, R1_q=0.
- Fetch:
  - T0: PCout+MARin+IncPC+Zin → MAR_q=0, Z_q low=1.
  - T1: Zlowout+PCin+Read+MDRin with MDatain=0x28918000 → PC=1, MDR=0x28918000.
  - T2: MDRout+IRin → IR_q=0x28918000.
- SUB execute with R2=10, R3=15: R2out+Yin, then R3out+SUB+Zin → Z_q=0xFFFFFFFF_FFFFFFFB. Then Zlowout+R1in → R1_q=0xFFFFFFFB.
- Reset mid-sequence: assert clr in the same cycle as R2in with bus=7 → R2_q=0 and PC=0 after the edge.
- Bus idle and priority:
  - No select asserted → BusMuxOut=0.
  - PCout and R2out together (PC=1, R2=10) → BusMuxOut=1.
- Cout: IR=0x0007FFFF, Cout → BusMuxOut=0xFFFFFFFF. IR=0x0003FFFF → 0x0003FFFF.
